ro_freq_meter_ctrl: RTL and testbench

Sequencing controller for the ring oscillator. It holds the oscillator stopped through its init input, releases it on request, and lets it settle. It then counts the oscillator's output pulses over a fixed gate window of system clock cycles and reports the count. It sits between the lab's control logic and the oscillator instance, which runs with init driven by this block and pulse fed back to it.

---
 rtl/ro_freq_meter_ctrl.sv | 130 +++++++++++++
 tb/tb_ro_freq_meter_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter_ctrl.sv
// Ring-oscillator frequency meter controller: holds the oscillator in init,
// releases it, waits SETTLE cycles, then counts synchronized rising edges for WINDOW cycles.
module ro_freq_meter_ctrl #(
  parameter int WINDOW      = 100,
  parameter int SETTLE      = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_pulse,
  output logic             ro_init,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int PH_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] SETTLE_END = PH_W'(SETTLE);
  localparam logic [PH_W-1:0] WINDOW_END = PH_W'(WINDOW);
  localparam logic [PH_W-1:0] PH_FIRST   = PH_W'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   ro_init_q, ro_init_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rise;

  assign ro_init  = ro_init_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = ovf_q;

  // prev_q holds the last synchronizer stage one cycle back for edge detection
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ro_pulse};
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Phase counter starts at 1 on state entry so the terminal compare
  // uses the parameter value itself.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          phase_d = PH_FIRST;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (phase_q == SETTLE_END) begin
          state_d = S_MEASURE;
          phase_d = PH_FIRST;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_MEASURE: begin
        if (rise) begin
          if (count_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
          else                          count_d = count_q + 1'b1;
        end
        if (phase_q == WINDOW_END) begin
          state_d = S_DONE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase
    ro_init_d = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d    = ~ro_init_d;
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ro_init_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ro_init_q <= ro_init_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ro_freq_meter_ctrl.sv
// Bench for ro_freq_meter_ctrl: a 16-bit and a 4-bit instance share stimulus;
// one time unit is 0.5 ns, so the clock period of 10 units is 5 ns.
module tb_ro_freq_meter_ctrl;

  typedef struct {
    int mode;      // 0 = square wave gated by ro_init, 1 = tied 0, 2 = tied 1
    int half_u;    // half period of the square wave in time units
    int lo, hi, ovf;
    int lo_s, hi_s, ovf_s;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start;
  logic ro_pulse;
  logic ro_init, busy, done, overflow;
  logic [15:0] count;
  logic ro_init_s, busy_s, done_s, overflow_s;
  logic [3:0] count_s;

  int mode = 0;
  int half_u = 20;
  logic sq = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  vec_t vecs[5];

  // clock / reset / pulse source
  always #5 clk = ~clk;

  always begin
    #(half_u);
    sq = ro_init ? 1'b0 : ~sq;
  end

  assign ro_pulse = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (sq & ~ro_init);

  ro_freq_meter_ctrl #(.WINDOW(100), .SETTLE(8), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .ro_pulse(ro_pulse),
    .ro_init(ro_init), .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  ro_freq_meter_ctrl #(.WINDOW(100), .SETTLE(8), .CNT_W(4), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .ro_pulse(ro_pulse),
    .ro_init(ro_init_s), .busy(busy_s), .done(done_s), .count(count_s), .overflow(overflow_s)
  );

  // scoreboard
  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // driver: one measurement starting from IDLE, checking per-cycle timing
  task automatic do_run(input vec_t v, input string tag);
    int ri_bad, busy_bad, done_bad;
    longint c109, o109, cs109, os109;
    ri_bad = 0; busy_bad = 0; done_bad = 0;
    c109 = 0; o109 = 0; cs109 = 0; os109 = 0;
    mode = v.mode;
    half_u = v.half_u;
    repeat (60) @(negedge clk);
    if (ro_init !== 1'b1) ri_bad++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      if (k > 1) @(negedge clk);
      if (ro_init !== ((k <= 108) ? 1'b0 : 1'b1)) ri_bad++;
      if (busy !== ((k <= 108) ? 1'b1 : 1'b0)) busy_bad++;
      if (done !== ((k == 109) ? 1'b1 : 1'b0)) done_bad++;
      if (done_s !== ((k == 109) ? 1'b1 : 1'b0)) done_bad++;
      if (k == 109) begin
        c109 = count; o109 = overflow; cs109 = count_s; os109 = overflow_s;
      end
    end
    check({tag, " ro_init_timing_errs"}, ri_bad, 0, 0);
    check({tag, " busy_timing_errs"}, busy_bad, 0, 0);
    check({tag, " done_at_109_errs"}, done_bad, 0, 0);
    check({tag, " count"}, c109, v.lo, v.hi);
    check({tag, " overflow"}, o109, v.ovf, v.ovf);
    check({tag, " count_w4"}, cs109, v.lo_s, v.hi_s);
    check({tag, " overflow_w4"}, os109, v.ovf_s, v.ovf_s);
    check({tag, " count_held_in_idle"}, count, c109, c109);
  endtask

  initial begin
    int ndone, d1, d2, bbad;
    vecs[0] = '{mode: 0, half_u: 20,  lo: 24, hi: 26, ovf: 0, lo_s: 15, hi_s: 15, ovf_s: 1};
    vecs[1] = '{mode: 0, half_u: 500, lo: 0,  hi: 2,  ovf: 0, lo_s: 0,  hi_s: 2,  ovf_s: 0};
    vecs[2] = '{mode: 1, half_u: 20,  lo: 0,  hi: 0,  ovf: 0, lo_s: 0,  hi_s: 0,  ovf_s: 0};
    vecs[3] = '{mode: 2, half_u: 20,  lo: 0,  hi: 0,  ovf: 0, lo_s: 0,  hi_s: 0,  ovf_s: 0};
    vecs[4] = '{mode: 0, half_u: 50,  lo: 9,  hi: 11, ovf: 0, lo_s: 9,  hi_s: 11, ovf_s: 0};

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ro_init", ro_init, 1, 1);
    check("reset busy", busy, 0, 0);
    check("reset done", done, 0, 0);
    check("reset count", count, 0, 0);
    check("reset overflow", overflow, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) do_run(vecs[i], $sformatf("vec%0d", i));

    // start held high: only IDLE samples it
    mode = 0; half_u = 20;
    repeat (60) @(negedge clk);
    ndone = 0; d1 = 0; d2 = 0; bbad = 0;
    start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) d1 = k;
        if (ndone == 2) d2 = k;
      end
      if ((k == 109 || k == 110 || k == 219) && busy !== 1'b0) bbad++;
    end
    start = 1'b0;
    check("held_start done_pulses", ndone, 2, 2);
    check("held_start first_done", d1, 109, 109);
    check("held_start second_done", d2, 219, 219);
    check("held_start busy_low_gaps", bbad, 0, 0);
    repeat (60) @(negedge clk);

    // reset in MEASURE cycle 50 discards the partial count
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (57) @(negedge clk);
    check("mid_rst busy_before", busy, 1, 1);
    check("mid_rst partial_count", count, 9, 14);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst ro_init", ro_init, 1, 1);
    check("mid_rst busy", busy, 0, 0);
    check("mid_rst count", count, 0, 0);
    check("mid_rst done", done, 0, 0);
    ndone = 0;
    for (int k = 0; k < 130; k++) begin
      @(negedge clk);
      if (done === 1'b1 || done_s === 1'b1) ndone++;
    end
    check("mid_rst no_done_after", ndone, 0, 0);
    do_run(vecs[0], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
